// File: rtl/utopia1_phy_tx.sv
// utopia1_phy_tx: PHY-side Utopia Level 1 Rx cell source.
// Buffers host cells in round-robin slots and delivers them under clav/en.
module utopia1_phy_tx #(
    parameter int unsigned NUM_CELLS  = 2,
    parameter bit          GEN_HEC    = 1'b1,
    parameter int unsigned CELL_BYTES = 53
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_soc,
    output logic        in_err,
    output logic [7:0]  data,
    output logic        soc,
    input  logic        en,
    output logic        clav,
    output logic [15:0] cells_sent
);
    localparam int unsigned DEPTH = NUM_CELLS * CELL_BYTES;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [5:0]  LAST  = 6'(CELL_BYTES - 1);
    localparam logic [1:0]  PMAX  = 2'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        SLOT_FREE, SLOT_FILL, SLOT_READY, SLOT_SEND
    } slot_e;

    typedef enum logic { IDLE, XFER } rd_state_e;

    logic [7:0]    mem_q [DEPTH];
    slot_e         slot_q [4];
    slot_e         slot_d [4];
    logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [5:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [2:0]    rcnt_q, rcnt_d;
    logic [7:0]    crc_q, crc_d, data_q, data_d;
    logic          soc_q, soc_d, clav_q, clav_d, err_q, err_d;
    logic [15:0]   sent_q, sent_d;
    rd_state_e     st_q, st_d;
    logic          accept, mem_we, rc_inc, rc_dec;
    logic [AW-1:0] wbase, raddr, waddr;
    logic [7:0]    wdata;

    // One MSB-first CRC-8 (x^8+x^2+x+1) byte step.
    function automatic logic [7:0] crc8_step(input logic [7:0] c,
                                             input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == PMAX) ? 2'd0 : p + 2'd1;
    endfunction

    assign in_ready   = !rst && (slot_q[wr_ptr_q] == SLOT_FREE ||
                                 slot_q[wr_ptr_q] == SLOT_FILL);
    assign accept     = in_valid && in_ready;
    assign wbase      = AW'(32'(wr_ptr_q) * CELL_BYTES);
    assign raddr      = AW'(32'(rd_ptr_q) * CELL_BYTES + 32'(rd_idx_q));
    assign data       = data_q;
    assign soc        = soc_q;
    assign clav       = clav_q;
    assign in_err     = err_q;
    assign cells_sent = sent_q;

    // Host write path, HEC generation and Utopia read FSM next state.
    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        crc_d    = crc_q;
        data_d   = data_q;
        soc_d    = 1'b0;
        err_d    = 1'b0;
        sent_d   = sent_q;
        st_d     = st_q;
        mem_we   = 1'b0;
        waddr    = wbase + AW'(wr_idx_q);
        wdata    = in_data;
        rc_inc   = 1'b0;
        rc_dec   = 1'b0;

        if (accept) begin
            if (in_soc) begin
                // A new start always restarts the slot at octet 0.
                err_d            = (wr_idx_q != 6'd0);
                mem_we           = 1'b1;
                waddr            = wbase;
                wr_idx_d         = 6'd1;
                crc_d            = crc8_step(8'h00, in_data);
                slot_d[wr_ptr_q] = SLOT_FILL;
            end else if (wr_idx_q == 6'd0) begin
                err_d = 1'b1;
            end else begin
                mem_we = 1'b1;
                if (GEN_HEC && wr_idx_q == 6'd4) begin
                    wdata = crc_q ^ 8'h55;
                end
                if (wr_idx_q < 6'd4) begin
                    crc_d = crc8_step(crc_q, in_data);
                end
                if (wr_idx_q == LAST) begin
                    wr_idx_d         = 6'd0;
                    slot_d[wr_ptr_q] = SLOT_READY;
                    wr_ptr_d         = ptr_next(wr_ptr_q);
                    rc_inc           = 1'b1;
                end else begin
                    wr_idx_d = wr_idx_q + 6'd1;
                end
            end
        end

        unique case (st_q)
            IDLE: begin
                if (!en && rcnt_q != 3'd0) begin
                    slot_d[rd_ptr_q] = SLOT_SEND;
                    rc_dec           = 1'b1;
                    data_d           = mem_q[raddr];
                    soc_d            = 1'b1;
                    rd_idx_d         = 6'd1;
                    st_d             = XFER;
                end
            end
            XFER: begin
                if (!en) begin
                    data_d = mem_q[raddr];
                    if (rd_idx_q == LAST) begin
                        slot_d[rd_ptr_q] = SLOT_FREE;
                        rd_ptr_d         = ptr_next(rd_ptr_q);
                        rd_idx_d         = 6'd0;
                        sent_d           = sent_q + 16'd1;
                        st_d             = IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + 6'd1;
                    end
                end
            end
        endcase

        rcnt_d = rcnt_q + {2'b00, rc_inc} - {2'b00, rc_dec};
        clav_d = (rcnt_d != 3'd0);
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            wr_idx_q <= 6'd0;
            rd_idx_q <= 6'd0;
            rcnt_q   <= 3'd0;
            crc_q    <= 8'h00;
            data_q   <= 8'h00;
            soc_q    <= 1'b0;
            clav_q   <= 1'b0;
            err_q    <= 1'b0;
            sent_q   <= 16'd0;
            st_q     <= IDLE;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            rcnt_q   <= rcnt_d;
            crc_q    <= crc_d;
            data_q   <= data_d;
            soc_q    <= soc_d;
            clav_q   <= clav_d;
            err_q    <= err_d;
            sent_q   <= sent_d;
            st_q     <= st_d;
        end
    end

    // Cell buffer storage; contents are gated by slot state, not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_utopia1_phy_tx.sv
// tb_utopia1_phy_tx: directed bench for the Utopia L1 PHY Rx cell source.
// Runs a GEN_HEC=1 and a GEN_HEC=0 instance side by side on one stimulus.
`timescale 1ns/1ps
module tb_utopia1_phy_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_soc = 1'b0;
    logic        en = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, in_err, soc, clav;
    logic        in_ready0, in_err0, soc0, clav0;
    logic [7:0]  data, data0;
    logic [15:0] cells_sent, cells_sent0;

    int          total = 0;
    int          bad = 0;
    int          n_sent = 0;
    logic [7:0]  rx [53];
    logic [7:0]  rx_h0;
    int          rx_socs;
    int          rx_wait;
    bit          load_done;

    typedef struct {
        logic [31:0] hdr;
        logic [7:0]  hec_in;
        logic [7:0]  base;
        logic [7:0]  exp_h1;
    } vec_t;

    vec_t vt [4];

    always #5 clk = ~clk;

    utopia1_phy_tx #(.NUM_CELLS(2), .GEN_HEC(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_soc(in_soc), .in_err(in_err),
        .data(data), .soc(soc), .en(en), .clav(clav),
        .cells_sent(cells_sent)
    );

    utopia1_phy_tx #(.NUM_CELLS(2), .GEN_HEC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_soc(in_soc), .in_err(in_err0),
        .data(data0), .soc(soc0), .en(en), .clav(clav0),
        .cells_sent(cells_sent0)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] cell_byte(input logic [31:0] hdr,
                                             input logic [7:0] b4,
                                             input logic [7:0] base,
                                             input int i);
        if (i < 4) return hdr[31-8*i -: 8];
        if (i == 4) return b4;
        return base + 8'(i);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic s);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_soc   = s;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=0 want 1");
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_soc   = 1'b0;
    endtask

    task automatic load_cell(input logic [31:0] hdr, input logic [7:0] b4,
                             input logic [7:0] base, input int first,
                             input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(cell_byte(hdr, b4, base, i), i == 0);
        end
    endtask

    task automatic recv_rest();
        for (int i = 1; i < 53; i++) begin
            @(negedge clk);
            rx[i] = data;
            if (i == 4) rx_h0 = data0;
            rx_socs += int'(soc);
        end
    endtask

    task automatic recv_cell();
        int t;
        t = 0;
        en = 1'b0;
        do begin
            @(negedge clk);
            t++;
        end while (!soc && t < 300);
        rx_wait = t;
        check("rx_soc_seen", soc, 1);
        rx[0]   = data;
        rx_socs = 1;
        recv_rest();
        en = 1'b1;
    endtask

    task automatic check_cell(input string name, input logic [31:0] hdr,
                              input logic [7:0] b4, input logic [7:0] base);
        int nbad;
        nbad = 0;
        for (int i = 0; i < 53; i++) begin
            if (rx[i] !== cell_byte(hdr, b4, base, i)) nbad++;
        end
        check({name, "_bad_octets"}, nbad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early, idx, socs, hold_bad;
        logic [15:0] sent103;

        vt[0] = '{32'h00000000, 8'hAA, 8'h10, 8'h55};
        vt[1] = '{32'h00100000, 8'hFF, 8'h20, 8'hF7};
        vt[2] = '{32'h00000001, 8'h00, 8'h40, 8'h52};
        vt[3] = '{32'h00000002, 8'h12, 8'h80, 8'h5B};

        // reset state
        repeat (2) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_soc", soc, 0);
        check("rst_clav", clav, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_in_err", in_err, 0);
        check("rst_sent", cells_sent, 0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", in_ready, 1);
        @(negedge clk);

        // single cell, en held low, clav timing
        en = 1'b0;
        load_cell(32'h0, 8'h00, 8'hFC, 0, 51);
        check("t1_clav_pre", clav, 0);
        send_byte(cell_byte(32'h0, 8'h00, 8'hFC, 52), 1'b0);
        check("t1_clav_rise", clav, 1);
        check("t1_soc_pre", soc, 0);
        recv_cell();
        n_sent++;
        check("t1_latency", rx_wait, 1);
        check("t1_hec", rx[4], 8'h55);
        check_cell("t1", 32'h0, 8'h55, 8'hFC);
        check("t1_socs", rx_socs, 1);
        check("t1_sent", cells_sent, n_sent);
        check("t1_clav_end", clav, 0);

        // HEC table on both instances
        for (int v = 0; v < 4; v++) begin
            load_cell(vt[v].hdr, vt[v].hec_in, vt[v].base, 0, 52);
            recv_cell();
            n_sent++;
            check($sformatf("hec%0d_gen1", v), rx[4], vt[v].exp_h1);
            check($sformatf("hec%0d_gen0", v), rx_h0, vt[v].hec_in);
            check_cell($sformatf("hec%0d", v), vt[v].hdr, vt[v].exp_h1,
                       vt[v].base);
            check($sformatf("hec%0d_socs", v), rx_socs, 1);
            check($sformatf("hec%0d_sent", v), cells_sent, n_sent);
        end

        // full buffer, single-cycle en pulse, back-to-back delivery
        load_cell(32'h0, 8'h00, 8'h30, 0, 52);
        load_cell(32'h1, 8'h00, 8'h50, 0, 52);
        check("full_rdy", in_ready, 0);
        check("full_clav", clav, 1);
        load_done = 1'b0;
        fork
            begin
                load_cell(32'h2, 8'h00, 8'h70, 0, 52);
                load_done = 1'b1;
            end
        join_none
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        check("pulse_soc", soc, 1);
        check("pulse_rdy", in_ready, 0);
        check("pulse_clav", clav, 1);
        rx[0] = data;
        repeat (3) @(negedge clk);
        check("pause_soc", soc, 0);
        check("pause_data", data, cell_byte(32'h0, 8'h55, 8'h30, 0));
        en = 1'b0;
        early = 0;
        for (int i = 1; i < 53; i++) begin
            @(negedge clk);
            rx[i] = data;
            if (i < 52 && in_ready) early++;
        end
        check("busy_rdy_cycles", early, 0);
        check("freed_rdy", in_ready, 1);
        n_sent++;
        check_cell("cellA", 32'h0, 8'h55, 8'h30);
        check("cellA_sent", cells_sent, n_sent);
        @(negedge clk);
        check("b2b_soc", soc, 1);
        rx[0]   = data;
        rx_socs = 1;
        recv_rest();
        en = 1'b1;
        n_sent++;
        check_cell("cellB", 32'h1, 8'h52, 8'h50);
        check("cellB_socs", rx_socs, 1);
        for (int t = 0; t < 400 && !load_done; t++) @(negedge clk);
        check("cellC_loaded", load_done, 1);
        recv_cell();
        n_sent++;
        check_cell("cellC", 32'h2, 8'h5B, 8'h70);
        check("cellC_sent", cells_sent, n_sent);

        // en toggling every clock during a transfer
        load_cell(32'h00100000, 8'hFF, 8'h90, 0, 52);
        idx = 0;
        socs = 0;
        hold_bad = 0;
        sent103 = 16'd0;
        en = 1'b0;
        for (int k = 0; k < 105; k++) begin
            @(negedge clk);
            socs += int'(soc);
            if (k % 2 == 0) begin
                rx[idx] = data;
                idx++;
            end else if (data !== cell_byte(32'h00100000, 8'hF7, 8'h90,
                                            idx - 1)) begin
                hold_bad++;
            end
            if (k == 103) sent103 = cells_sent;
            en = ~en;
        end
        en = 1'b1;
        check_cell("toggle", 32'h00100000, 8'hF7, 8'h90);
        check("tog_hold_bad", hold_bad, 0);
        check("tog_socs", socs, 1);
        check("tog_sent_at104", sent103, n_sent);
        n_sent++;
        check("tog_sent_at105", cells_sent, n_sent);

        // host framing errors
        load_cell(32'h0, 8'h00, 8'hA0, 0, 19);
        check("frm_no_err", in_err, 0);
        load_cell(32'h1, 8'h00, 8'hB0, 0, 0);
        check("frm_err_soc", in_err, 1);
        load_cell(32'h1, 8'h00, 8'hB0, 1, 1);
        check("frm_err_pulse", in_err, 0);
        load_cell(32'h1, 8'h00, 8'hB0, 2, 52);
        recv_cell();
        n_sent++;
        check_cell("frm_resync", 32'h1, 8'h52, 8'hB0);
        send_byte(8'h77, 1'b0);
        check("frm_err_drop", in_err, 1);
        load_cell(32'h2, 8'h00, 8'hC0, 0, 52);
        check("frm_err_clr", in_err, 0);
        recv_cell();
        n_sent++;
        check_cell("frm_after_drop", 32'h2, 8'h5B, 8'hC0);
        check("frm_sent", cells_sent, n_sent);

        // asynchronous reset in the middle of a transfer
        load_cell(32'h0, 8'h00, 8'hD0, 0, 52);
        load_cell(32'h1, 8'h00, 8'hE0, 0, 52);
        en = 1'b0;
        for (int t = 0; t < 300 && !soc; t++) @(negedge clk);
        repeat (29) @(negedge clk);
        check("mid_data", data, cell_byte(32'h0, 8'h55, 8'hD0, 29));
        check("mid_clav", clav, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_data", data, 0);
        check("arst_soc", soc, 0);
        check("arst_clav", clav, 0);
        check("arst_sent", cells_sent, 0);
        check("arst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        n_sent = 0;
        #1;
        check("rel_in_ready", in_ready, 1);
        socs = 0;
        repeat (10) begin
            @(negedge clk);
            socs += int'(soc);
        end
        check("empty_socs", socs, 0);
        check("empty_clav", clav, 0);
        check("empty_data", data, 0);
        en = 1'b1;
        load_cell(32'h2, 8'h33, 8'hF0, 0, 52);
        recv_cell();
        n_sent++;
        check_cell("post_rst", 32'h2, 8'h5B, 8'hF0);
        check("post_rst_sent", cells_sent, n_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/utopia1_phy_tx.md
Name: utopia1_phy_tx

Overview:
- PHY-side Utopia Level 1 cell source for one SQUAT Rx port; drives Rx_data/Rx_soc/Rx_clav and samples Rx_en from the ATM-layer receiver.
- A host/bench byte stream loads complete 53-byte cells into an internal multi-cell buffer.
- Cells are delivered under cell-level handshake (clav), with optional HEC (CRC-8) regeneration.
- Synthesizable; the bench uses it as a PHY stand-in.

Parameters:
- NUM_CELLS, 2, cell slots in buffer (2..4).
- GEN_HEC, 1, 1 = overwrite byte 4 with computed HEC; 0 = pass byte 4 through unchanged.
- CELL_BYTES, 53, octets per cell (fixed 53; not to be overridden).

Ports:
- clk  in  1  Utopia Rx clock, also host clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_ready  out  1  host byte accepted when in_valid && in_ready at posedge.
- in_data  in  8  host cell octet.
- in_soc  in  1  marks first octet of a host cell.
- in_err  out  1  one-cycle pulse: framing error on host side.
- data  out  8  Utopia Rx_data to ATM layer.
- soc  out  1  Utopia Rx_soc, high with octet 0.
- en  in  1  Utopia Rx_en, active low, driven by ATM layer.
- clav  out  1  Utopia Rx_clav: at least one complete unstarted cell buffered.
- cells_sent  out  16  count of cells fully delivered, wraps at 0xFFFF->0.

Behaviour:
- Reset (async, any time incl. mid-cell): data=0, soc=0, clav=0, in_ready=0 while rst=1, in_err=0, cells_sent=0.
- Reset also clears all slot states, pointers and the CRC register.
- in_ready=1 on the first clk after rst deasserts if any slot is free.
- Slot states: FREE -> FILLING -> READY -> SENDING -> FREE.
  - Write pointer and read pointer each rotate round-robin over the slots.
  - ready_cnt counts READY slots.
- Host write path:
  - in_ready = current write slot is FREE or FILLING.
  - Accepted byte is stored at wr_idx (0..52), then wr_idx increments.
  - On wr_idx==52 the slot goes READY, ready_cnt+1, and the write pointer advances.
- Host framing:
  - in_soc=1 at wr_idx!=0: discard partial cell, store this byte as octet 0 (wr_idx=1), pulse in_err.
  - in_soc=0 at wr_idx==0: drop byte, pulse in_err, wr_idx stays 0.
- HEC (GEN_HEC=1):
  - Running CRC-8, poly x^8+x^2+x+1 (0x07), init 0x00, MSB first, over octets 0..3.
  - Octet 4 is stored as crc^0x55; the host value of octet 4 is ignored. The CRC register is cleared at octet 0.
- Utopia read state machine, states IDLE, XFER:
  - IDLE: at posedge with en==0 and ready_cnt>0, start the read slot (READY->SENDING, ready_cnt-1, rd_idx=0) and in the same edge register data=octet0, soc=1; go to XFER with rd_idx=1.
  - IDLE with en==1, or ready_cnt==0: data holds, soc=0. An en low while clav is low is ignored.
  - XFER, en==0 at posedge: data=octet[rd_idx], soc=0, rd_idx+1.
  - XFER, after octet 52 is driven: slot -> FREE, read pointer advances, cells_sent+1, return to IDLE.
  - XFER, en==1 at posedge: pause; data holds last octet, soc=0, rd_idx unchanged. Resume on the next en==0.
  - Latency: each octet appears on data/soc one clk after the edge that sampled en low. Back-to-back cells need no gap: en held low across the boundary starts the next READY cell on the edge after octet 52.
- clav is registered: clav <= (next ready_cnt != 0).
  - clav drops on the same edge that starts the last READY cell.
  - Simultaneous host completion and read start: ready_cnt is unchanged and clav stays 1.
- Full: all slots READY/SENDING -> in_ready=0; a slot freeing at posedge raises in_ready on that edge.
- Empty: clav=0; data/soc idle as above.

Test Plan:
- Reset then load one cell (octets 0..3 = 00 00 00 00, payload 0x01..0x30), GEN_HEC=1, hold en=0 -> clav rises 1 clk after octet 52 is accepted. Delivery: soc=1 with octet 00, octet 4 = 0x55, 53 octets contiguous, cells_sent=1, clav=0.
- Header 0x00 0x10 0x00 0x00 with host HEC byte 0xFF, GEN_HEC=1 -> delivered octet 4 equals the CRC-8(0x07)^0x55 reference value, not 0xFF. The same cell with GEN_HEC=0 -> 0xFF delivered.
- Load 3 cells with NUM_CELLS=2 and en held high -> in_ready=0 after 106 bytes. Pulse en low for a single cycle -> cell 0 starts, and in_ready stays 0 until cell 0 completes.
- en toggles 0/1 every clk during a transfer -> octets still in order with no duplicates. Each paused cycle holds data, soc is asserted only once, and the cell completes in 105 clks.
- Host sends in_soc=1 at wr_idx=20 -> in_err pulses, the partial cell is discarded, and the next delivered cell starts from the new octet 0. A byte with in_soc=0 at index 0 -> in_err pulses and the byte is dropped.
- Assert rst mid-XFER at rd_idx=30 -> all outputs 0 immediately (async), cells_sent=0, clav=0. After release the buffer is empty and a new load delivers correctly.
